serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_sub.sv | 13 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial adder/subtractor blocks: FSM encodings and default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Purely combinational one-bit full subtractor cell: D = X - Y - Bin with borrow out.
module FullSubtractor (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = X ^ Y ^ Bin;
    assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per clock through a single FullSubtractor cell.
//
//  state | meaning
//  IDLE  | waiting for START; D/BOUT hold the last result
//  SHIFT | one operand bit processed per cycle, BUSY high
//  FIN   | result valid, DONE pulses for this single cycle
module serial_subtractor #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);
    import serial_subtractor_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             diff_bit;
    logic             borrow_nxt;

    FullSubtractor u_cell (
        .X    (a_q[0]),
        .Y    (b_q[0]),
        .Bin  (borrow_q),
        .D    (diff_bit),
        .Bout (borrow_nxt)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                // Diff bits enter at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
                d_d      = {diff_bit, d_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    // The borrow flop is only cleared by the next accepted START, so it doubles as BOUT.
    assign BUSY = (state_q == ST_SHIFT);
    assign DONE = (state_q == ST_FIN);
    assign D    = d_q;
    assign BOUT = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, random ops, and multi-cycle corner cases.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A, B;
    logic         BUSY, DONE, BOUT;
    logic [W-1:0] D;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bout;
    } vec_t;

    vec_t vecs[6];

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ai, bi, di;
        ai = a;
        bi = b;
        di = (ai + (1 << W) - bi) % (1 << W);
        return {(ai < bi), di[W-1:0]};
    endfunction

    // One operation: START sampled at edge k; BUSY high for the W cycles after k,
    // DONE only in the cycle after edge k+W, then IDLE with the result held.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d, input logic exp_bout);
        bit ok;
        logic [W-1:0] d_done;
        logic         bout_done;
        ok = 1'b1;
        @(negedge CLK);
        START = 1'b1; A = a; B = b;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0; A = W'($urandom); B = W'($urandom);
        for (int j = 0; j <= W; j++) begin
            if (j > 0) @(negedge CLK);
            if (BUSY !== (j < W) || DONE !== (j == W)) ok = 1'b0;
        end
        d_done    = D;
        bout_done = BOUT;
        check({name, "_d"}, 32'(d_done), 32'(exp_d));
        check({name, "_bout"}, 32'(bout_done), 32'(exp_bout));
        @(negedge CLK);
        if (DONE !== 1'b0 || BUSY !== 1'b0 || D !== d_done || BOUT !== bout_done) ok = 1'b0;
        check({name, "_timing"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0]   r;
        logic [W-1:0] ra, rb;
        int           dones, done_at;
        logic [W-1:0] d_seen;
        logic         bout_seen;
        logic [W-1:0] qa[$], qb[$];
        int           last_done;
        logic [W-1:0] ea, eb;

        vecs[0] = '{a: 8'h5A, b: 8'h23, d: 8'h37, bout: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h20, d: 8'hF0, bout: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, d: 8'h00, bout: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bout: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bout: 1'b0};

        RST = 1'b1; START = 1'b1; A = 8'hAA; B = 8'h55;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        check("rst_bout", 32'(BOUT), 32'd0);
        RST = 1'b0; START = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bout);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            r  = ref_sub(ra, rb);
            do_op($sformatf("rnd%0d", i), ra, rb, r[W-1:0], r[W]);
        end

        // START mid-SHIFT must be ignored.
        @(negedge CLK);
        START = 1'b1; A = 8'h5A; B = 8'h23;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        dones = 0; done_at = -1; d_seen = '0; bout_seen = 1'b0;
        for (int j = 1; j <= W + 4; j++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                dones++;
                done_at   = j;
                d_seen    = D;
                bout_seen = BOUT;
            end
            if (j == 3) begin START = 1'b1; A = 8'h44; B = 8'h11; end
            if (j == 4) START = 1'b0;
        end
        check("midstart_ndone", 32'(dones), 32'd1);
        check("midstart_when", 32'(done_at), 32'(W));
        check("midstart_d", 32'(d_seen), 32'h37);
        check("midstart_bout", 32'(bout_seen), 32'd0);

        // Reset during SHIFT aborts with no DONE.
        @(negedge CLK);
        START = 1'b1; A = 8'h5A; B = 8'h23;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_d", 32'(D), 32'd0);
        check("abort_bout", 32'(BOUT), 32'd0);
        dones = 0;
        for (int j = 0; j < W + 3; j++) begin
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
        end
        check("abort_nodone", 32'(dones), 32'd0);
        do_op("after_abort", 8'h09, 8'h03, 8'h06, 1'b0);

        // START held high: back-to-back ops every W+2 cycles.
        @(negedge CLK);
        START = 1'b1;
        A = W'($urandom); B = W'($urandom);
        qa.push_back(A); qb.push_back(B);
        dones = 0; last_done = -1;
        for (int cyc = 1; cyc <= 5 * (W + 2); cyc++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                dones++;
                ea = qa.pop_front();
                eb = qb.pop_front();
                r  = ref_sub(ea, eb);
                check($sformatf("b2b%0d_d", dones), 32'(D), 32'(r[W-1:0]));
                check($sformatf("b2b%0d_bout", dones), 32'(BOUT), 32'(r[W]));
                if (last_done >= 0)
                    check($sformatf("b2b%0d_period", dones), 32'(cyc - last_done), 32'(W + 2));
                last_done = cyc;
                A = W'($urandom); B = W'($urandom);
                qa.push_back(A); qb.push_back(B);
            end
        end
        check("b2b_count", 32'(dones), 32'd5);
        START = 1'b0;
        repeat (W + 4) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
